frame_former_scheduler: RTL and testbench
=========================================

// Module: frame_former_scheduler
// PURPOSE
//  Round-robin scheduler sharing one downstream AXI-Stream framer port between NUM_SRC frame-former buffers.
//  Picks an eligible buffer (enough data, or data aged past timeout), pops it beat-by-beat into a registered
//  M_AXIS output, and closes the frame with tlast at MAX_FRAME_BEATS or when the buffer drains.
//  Sits between the per-source buffers (head data, occupancy, pop) and the Ethernet framer.
// PARAMETERS
//  NUM_SRC          2   number of source buffers (>=1)
//  DATA_WIDTH       64  beat width; fixed at 64 (tkeep is 8 bits)
//  LVL_W            7   width of each source occupancy count ($clog2(depth)+1)
//  START_THRESH     8   occupancy at which a source is eligible immediately
//  MAX_FRAME_BEATS  16  max beats per frame (>=1)
//  IDLE_TIMEOUT     32  cycles a non-empty source waits before it becomes eligible below threshold
// PORTS
//  ACLK           in   1                   clock, all logic on posedge
//  ARESETN        in   1                   asynchronous active-low reset
//  src_data       in   NUM_SRC*DATA_WIDTH  head word of each buffer, slice i = source i
//  src_level      in   NUM_SRC*LVL_W       occupancy of each buffer; updates on the same edge as a pop
//  src_pop        out  NUM_SRC             one-cycle pop strobe per source, one-hot or zero
//  M_AXIS_tdata   out  DATA_WIDTH          frame beat to framer
//  M_AXIS_tkeep   out  8                   always 8'hFF
//  M_AXIS_tvalid  out  1                   beat valid
//  M_AXIS_tlast   out  1                   last beat of frame
//  M_AXIS_tready  in   1                   framer accepts beat
//  grant_id       out  $clog2(NUM_SRC)>0?$clog2(NUM_SRC):1  source currently or last granted
//  busy           out  1                   high in STREAM state
//  frame_count    out  16                  frames completed (wraps at 2^16)
// BEHAVIOUR
//  Reset (async, ARESETN=0): state=IDLE, tvalid=0, tlast=0, tdata=0, src_pop=0, grant_id=0, busy=0,
//   frame_count=0, all wait_cnt=0, rr_ptr=NUM_SRC-1 (so source 0 has first priority).
//   Outputs go to reset values immediately, mid-frame included; a partial frame is dropped without tlast.
//  wait_cnt[i]: 0 when level[i]==0 or while source i is granted; otherwise +1 per cycle, saturating at IDLE_TIMEOUT.
//  eligible[i] = level[i]>=START_THRESH || (level[i]!=0 && wait_cnt[i]==IDLE_TIMEOUT).
//  FSM IDLE: no pops, no loads. If any source is eligible, pick the first eligible index scanning
//   rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. On the next edge: grant_id<=idx, beat_cnt<=0, state<=STREAM.
//  FSM STREAM (g = grant_id):
//   load = (!tvalid || tready) && !last_loaded && level[g]!=0.
//   On load: src_pop[g]=1 for that cycle (combinational from load), tdata<=src_data[g], tvalid<=1,
//   beat_cnt<=beat_cnt+1, tlast<=(beat_cnt==MAX_FRAME_BEATS-1 || level[g]==1), last_loaded<=that value.
//   If tvalid&&tready and no load in that cycle: tvalid<=0.
//   When tvalid&&tready&&tlast: frame_count+1, rr_ptr<=g, last_loaded<=0, tvalid<=0, state<=IDLE.
//  Back-to-back throughput: one beat per cycle while tready=1 and data is present.
//   Latency: eligible seen at edge N -> STREAM at N+1 -> first tvalid at N+2.
//  Back-pressure: tvalid&&!tready holds tdata/tlast stable and src_pop=0.
//  A push and a pop on the same cycle are handled by the buffer; a level of 1 sampled at load always closes the frame.
//  Never pops a source whose level is 0; never pops an ungranted source; never emits a beat without a prior pop.
// TESTING
//  T1 reset: hold ARESETN=0 -> tvalid=0, src_pop=0, frame_count=0, busy=0, tkeep=8'hFF.
//  T2 src0 level 20, tready=1 -> 16-beat frame with tlast on beat 16, then a 4-beat frame with tlast on beat 4;
//     data order matches pop order; frame_count=2.
//  T3 both sources level>=8, MAX=16 -> grants alternate 0,1,0,1; no source is granted twice in a row.
//  T4 src1 level 3 only -> first tvalid 2 cycles after wait_cnt reaches 32; 3-beat frame, tlast on beat 3.
//  T5 tready=0 for 5 cycles mid-frame -> tdata/tlast stable, zero pops; resumes without loss or duplication.
//  T6 ARESETN pulsed low at beat 7 -> tvalid drops asynchronously; after release the next frame starts cleanly.

Source files
------------

// File: rtl/frame_former_scheduler_if.sv
// AXI-Stream beat channel from the frame-former scheduler to the Ethernet framer.
// The scheduler drives the master side; the framer only returns tready.
interface frame_former_scheduler_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [7:0]            tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/frame_former_scheduler.sv
// Round-robin scheduler that drains NUM_SRC frame-former buffers, one frame at a time,
// into a single registered AXI-Stream port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no frame open; arbitrate among eligible sources
// ST_STREAM | frame open on grant_id; pop and forward beats until tlast is taken
module frame_former_scheduler #(
    parameter int NUM_SRC         = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int LVL_W           = 7,
    parameter int START_THRESH    = 8,
    parameter int MAX_FRAME_BEATS = 16,
    parameter int IDLE_TIMEOUT    = 32,
    localparam int GW             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC*LVL_W-1:0]      src_level,
    output logic [NUM_SRC-1:0]            src_pop,
    frame_former_scheduler_if.master      M_AXIS,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [15:0]                   frame_count
);
    localparam int WCW = $clog2(IDLE_TIMEOUT + 1);
    localparam int BCW = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [LVL_W-1:0] THRESH    = LVL_W'(START_THRESH);
    localparam logic [WCW-1:0]   WAIT_MAX  = WCW'(IDLE_TIMEOUT);
    localparam logic [BCW-1:0]   BEAT_LAST = BCW'(MAX_FRAME_BEATS - 1);
    localparam logic [GW-1:0]    RR_INIT   = GW'(NUM_SRC - 1);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t                state;
    logic [LVL_W-1:0]      lvl      [NUM_SRC];
    logic [DATA_WIDTH-1:0] dat      [NUM_SRC];
    logic [WCW-1:0]        wait_cnt [NUM_SRC];
    logic [NUM_SRC-1:0]    eligible;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         pick_idx;
    logic                  pick_valid;
    logic [BCW-1:0]        beat_cnt;
    logic                  last_loaded;
    logic                  load;
    logic                  close_frame;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;

    genvar gi;
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign lvl[gi]      = src_level[gi*LVL_W +: LVL_W];
        assign dat[gi]      = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign eligible[gi] = (lvl[gi] >= THRESH) ||
                              ((lvl[gi] != '0) && (wait_cnt[gi] == WAIT_MAX));
    end

    // Scan from rr_ptr+1 upward; iterating downward lets the nearest candidate win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    assign load = (state == ST_STREAM) && (!tvalid_q || M_AXIS.tready) &&
                  !last_loaded && (lvl[grant_id] != '0);
    assign close_frame = (beat_cnt == BEAT_LAST) || (lvl[grant_id] == LVL_W'(1));

    always_comb begin
        src_pop = '0;
        if (load) src_pop[grant_id] = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((lvl[i] == '0) || ((state == ST_STREAM) && (grant_id == GW'(i))))
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_MAX)
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            rr_ptr      <= RR_INIT;
            beat_cnt    <= '0;
            last_loaded <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // tlast in flight implies last_loaded, so frame close and load never coincide
                    if (tvalid_q && M_AXIS.tready && tlast_q) begin
                        frame_count <= frame_count + 16'd1;
                        rr_ptr      <= grant_id;
                        last_loaded <= 1'b0;
                        tvalid_q    <= 1'b0;
                        tlast_q     <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (load) begin
                        tdata_q     <= dat[grant_id];
                        tvalid_q    <= 1'b1;
                        beat_cnt    <= beat_cnt + 1'b1;
                        tlast_q     <= close_frame;
                        last_loaded <= close_frame;
                    end else if (tvalid_q && M_AXIS.tready) begin
                        tvalid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M_AXIS.tdata  = tdata_q;
    assign M_AXIS.tkeep  = 8'hFF;
    assign M_AXIS.tvalid = tvalid_q;
    assign M_AXIS.tlast  = tlast_q;
endmodule

// File: tb/tb_frame_former_scheduler.sv
// Directed bench for frame_former_scheduler: the bench owns the source buffers as queues and
// checks every accepted beat against the per-source word sequence and frame-closing rules.
module tb_frame_former_scheduler;
    localparam int NUM_SRC = 2;
    localparam int DW      = 64;
    localparam int LVL_W   = 7;
    localparam int MAXB    = 16;

    logic                      ACLK = 1'b0;
    logic                      ARESETN = 1'b0;
    logic [NUM_SRC*DW-1:0]     src_data;
    logic [NUM_SRC*LVL_W-1:0]  src_level;
    logic [NUM_SRC-1:0]        src_pop;
    logic                      grant_id;
    logic                      busy;
    logic [15:0]               frame_count;

    frame_former_scheduler_if #(.DATA_WIDTH(DW)) axis ();

    frame_former_scheduler #(
        .NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .LVL_W(LVL_W), .START_THRESH(8),
        .MAX_FRAME_BEATS(MAXB), .IDLE_TIMEOUT(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .src_data(src_data), .src_level(src_level),
        .src_pop(src_pop), .M_AXIS(axis), .grant_id(grant_id), .busy(busy),
        .frame_count(frame_count)
    );

    always #5 ACLK = ~ACLK;

    // source buffers and model state
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int total[NUM_SRC];
    int acc[NUM_SRC];
    int beats;
    int frames;
    int log_src[$];
    int log_len[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] mk_word(int s, int k);
        return {8'(s), 24'hC0FFEE, 32'(k)};
    endfunction

    function automatic void refresh();
        src_data[63:0]    = (q0.size() > 0) ? q0[0] : 64'd0;
        src_data[127:64]  = (q1.size() > 0) ? q1[0] : 64'd0;
        src_level[6:0]    = 7'(q0.size());
        src_level[13:7]   = 7'(q1.size());
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int s, int n);
        for (int i = 0; i < n; i++) begin
            if (s == 0) q0.push_back(mk_word(0, total[0]));
            else        q1.push_back(mk_word(1, total[1]));
            total[s]++;
        end
        refresh();
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int i = 0; i < NUM_SRC; i++) begin
            total[i] = 0;
            acc[i]   = 0;
        end
        beats  = 0;
        frames = 0;
        log_src.delete();
        log_len.delete();
        refresh();
    endtask

    task automatic do_reset();
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        clear_model();
        repeat (3) @(posedge ACLK);
        #2 ARESETN = 1'b1;
    endtask

    task automatic wait_frames(int n, int budget);
        int c;
        c = 0;
        while (log_src.size() < n && c < budget) begin
            @(negedge ACLK); #1;
            c++;
        end
        if (log_src.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_frames actual=%0d required=%0d", log_src.size(), n);
        end
    endtask

    task automatic wait_acc(int s, int n, int budget);
        int c;
        c = 0;
        while (acc[s] < n && c < budget) begin
            @(negedge ACLK); #1;
            c++;
        end
        if (acc[s] < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_acc actual=%0d required=%0d", acc[s], n);
        end
    endtask

    task automatic check_frame(string name, int idx, int src, int len);
        check({name, "_present"}, 64'(log_src.size() > idx), 64'd1);
        check({name, "_src"}, 64'(log_src[idx]), 64'(src));
        check({name, "_len"}, 64'(log_len[idx]), 64'(len));
    endtask

    // buffer side: pops seen mid-cycle are applied just after the next edge
    initial begin
        logic [NUM_SRC-1:0] p;
        forever begin
            @(negedge ACLK);
            p = src_pop;
            @(posedge ACLK); #1;
            if (p[0] && q0.size() > 0) void'(q0.pop_front());
            if (p[1] && q1.size() > 0) void'(q1.pop_front());
            refresh();
        end
    end

    // compare process
    initial begin
        int s;
        logic exp_last;
        logic prev_stall;
        logic [63:0] prev_data;
        logic prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                prev_stall = 1'b0;
                continue;
            end
            check("tkeep", 64'(axis.tkeep), 64'hFF);
            check("pop_onehot", 64'($onehot0(src_pop)), 64'd1);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_pop[i]) begin
                    check("pop_granted", 64'({busy, grant_id}), 64'({1'b1, 1'(i)}));
                    check("pop_nonempty", 64'(src_level[i*LVL_W +: LVL_W] != 0), 64'd1);
                end
            end
            check("frame_count", 64'(frame_count), 64'(16'(frames)));
            if (prev_stall) begin
                check("stall_valid", 64'(axis.tvalid), 64'd1);
                check("stall_data", axis.tdata, prev_data);
                check("stall_last", 64'(axis.tlast), 64'(prev_last));
            end
            if (axis.tvalid && !axis.tready) check("stall_pop", 64'(src_pop), 64'd0);
            if (axis.tvalid && axis.tready) begin
                s = int'(grant_id);
                beats++;
                check("beat_data", axis.tdata, mk_word(s, acc[s]));
                exp_last = (beats == MAXB) || (acc[s] + 1 == total[s]);
                check("beat_last", 64'(axis.tlast), 64'(exp_last));
                acc[s]++;
                if (axis.tlast) begin
                    log_src.push_back(s);
                    log_len.push_back(beats);
                    frames++;
                    beats = 0;
                end
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        axis.tready = 1'b1;
        clear_model();

        // T1: reset held
        repeat (3) @(posedge ACLK);
        #2;
        check("t1_tvalid", 64'(axis.tvalid), 64'd0);
        check("t1_tlast", 64'(axis.tlast), 64'd0);
        check("t1_tdata", axis.tdata, 64'd0);
        check("t1_pop", 64'(src_pop), 64'd0);
        check("t1_frame_count", 64'(frame_count), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_grant", 64'(grant_id), 64'd0);
        check("t1_tkeep", 64'(axis.tkeep), 64'hFF);
        ARESETN = 1'b1;

        // T2: one source, 20 words -> 16 + 4
        @(posedge ACLK); #1;
        push(0, 20);
        wait_frames(2, 300);
        @(posedge ACLK); #1;
        check_frame("t2_f0", 0, 0, 16);
        check_frame("t2_f1", 1, 0, 4);
        check("t2_frame_count", 64'(frame_count), 64'd2);

        // T3: both sources full -> alternating grants
        do_reset();
        @(posedge ACLK); #1;
        push(0, 32);
        push(1, 32);
        wait_frames(4, 400);
        check_frame("t3_f0", 0, 0, 16);
        check_frame("t3_f1", 1, 1, 16);
        check_frame("t3_f2", 2, 0, 16);
        check_frame("t3_f3", 3, 1, 16);

        // T4: below threshold, eligible only by timeout
        do_reset();
        @(posedge ACLK); #1;
        push(1, 3);
        c = 0;
        while (c < 100) begin
            @(posedge ACLK);
            c++;
            @(negedge ACLK);
            if (axis.tvalid) break;
        end
        check("t4_first_valid_cycles", 64'(c), 64'd34);
        wait_frames(1, 50);
        check_frame("t4_f0", 0, 1, 3);

        // T5: back-pressure mid-frame
        do_reset();
        @(posedge ACLK); #1;
        push(0, 10);
        wait_acc(0, 3, 100);
        @(posedge ACLK); #1;
        axis.tready = 1'b0;
        repeat (5) @(posedge ACLK);
        #1 axis.tready = 1'b1;
        wait_frames(1, 100);
        check_frame("t5_f0", 0, 0, 10);

        // T6: async reset at beat 7 drops the partial frame
        do_reset();
        @(posedge ACLK); #1;
        push(0, 20);
        wait_acc(0, 7, 100);
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        check("t6_tvalid", 64'(axis.tvalid), 64'd0);
        check("t6_tlast", 64'(axis.tlast), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pop", 64'(src_pop), 64'd0);
        check("t6_frame_count", 64'(frame_count), 64'd0);
        check("t6_remaining", 64'(q0.size()), 64'd12);
        acc[0] = total[0] - q0.size();
        beats  = 0;
        frames = 0;
        log_src.delete();
        log_len.delete();
        repeat (2) @(posedge ACLK);
        #2 ARESETN = 1'b1;
        wait_frames(1, 100);
        @(posedge ACLK); #1;
        check_frame("t6_f0", 0, 0, 12);
        check("t6_frame_count_end", 64'(frame_count), 64'd1);

        repeat (3) @(posedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
